// File: rtl/fire_bank_reader_if.sv
// Beat stream from fire_bank_reader to its downstream consumer.
// The producer drives data/valid/last and the consumer drives ready.
interface fire_bank_reader_if #(
  parameter int LANES = 8
);
  logic [16*LANES-1:0] m_data;
  logic                m_valid;
  logic                m_ready;
  logic                m_last;

  modport master (output m_data, output m_valid, output m_last, input m_ready);
  modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/fire_bank_reader.sv
// Burst reader over LANES parallel 16-bit banks with combinational read data.
// Each read lands in a 2-entry FIFO that feeds a valid/ready beat stream.
module fire_bank_reader #(
  parameter int LANES  = 8,
  parameter int DEPTH  = 12321,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W-1:0]   pix_count,
  input  logic                abort,
  output logic                rden,
  output logic [ADDR_W-1:0]   address2,
  input  logic [16*LANES-1:0] bank_data,
  fire_bank_reader_if.master  m_if,
  output logic                busy,
  output logic                done,
  output logic                err
);
  localparam int DW = 16*LANES;
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] ONE_A   = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ZERO_A  = {ADDR_W{1'b0}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] hold_q, hold_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [DW-1:0]     data_q [2];
  logic [DW-1:0]     data_d [2];
  logic [1:0]        last_q, last_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        occ_q, occ_d;

  logic              req_s, zero_s, accept_s, bad_s;
  logic [ADDR_W:0]   sum_s;
  logic              range_ok_s;
  logic              valid_s, head_last_s, pop_s, issue_s, final_s, finish_s;
  logic [1:0]        occ_after_pop_s;

  // Start qualification; the range sum is one bit wider so it cannot wrap.
  assign req_s      = (state_q == IDLE) && start && !abort;
  assign sum_s      = {1'b0, base_addr} + {1'b0, pix_count};
  assign range_ok_s = (sum_s <= DEPTH_L);
  assign zero_s     = req_s && (pix_count == ZERO_A);
  assign accept_s   = req_s && (pix_count != ZERO_A) && range_ok_s;
  assign bad_s      = req_s && (pix_count != ZERO_A) && !range_ok_s;

  // A read may issue only if the FIFO still has a free slot after this cycle's pop.
  assign valid_s         = (occ_q != 2'd0);
  assign head_last_s     = last_q[rd_ptr_q];
  assign pop_s           = valid_s && m_if.m_ready;
  assign occ_after_pop_s = occ_q - {1'b0, pop_s};
  assign issue_s         = rst && !abort && (state_q == READ) && (occ_after_pop_s < 2'd2);
  assign final_s         = (idx_q == (cnt_q - ONE_A));
  assign finish_s        = rst && !abort && (state_q == DRAIN) && pop_s && head_last_s;

  // Next-state logic for the burst FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) state_d = READ;
        else          state_d = IDLE;
      end
      READ: begin
        if (abort)                   state_d = IDLE;
        else if (issue_s && final_s) state_d = DRAIN;
        else                         state_d = READ;
      end
      DRAIN: begin
        if (abort)                        state_d = IDLE;
        else if (pop_s && head_last_s)    state_d = IDLE;
        else                              state_d = DRAIN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Burst bookkeeping: next address, issue index, and start-response pulses.
  always_comb begin
    rd_addr_d = rd_addr_q;
    hold_d    = hold_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    done_d    = zero_s;
    err_d     = bad_s;
    if (accept_s) begin
      rd_addr_d = base_addr;
      idx_d     = ZERO_A;
      cnt_d     = pix_count;
    end else if (issue_s) begin
      rd_addr_d = rd_addr_q + ONE_A;
      hold_d    = rd_addr_q;
      idx_d     = idx_q + ONE_A;
    end else begin
      rd_addr_d = rd_addr_q;
    end
  end

  // FIFO next state; abort flushes occupancy and pointers but leaves storage.
  always_comb begin
    data_d   = data_q;
    last_d   = last_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (abort) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      occ_d    = 2'd0;
    end else begin
      if (issue_s) begin
        data_d[wr_ptr_q] = bank_data;
        last_d[wr_ptr_q] = final_s;
        wr_ptr_d         = ~wr_ptr_q;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) rd_ptr_d = ~rd_ptr_q;
      else       rd_ptr_d = rd_ptr_q;
      occ_d = occ_after_pop_s + {1'b0, issue_s};
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Datapath and FIFO registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_addr_q <= ZERO_A;
      hold_q    <= ZERO_A;
      idx_q     <= ZERO_A;
      cnt_q     <= ZERO_A;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      data_q[0] <= {DW{1'b0}};
      data_q[1] <= {DW{1'b0}};
      last_q    <= 2'b00;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      occ_q     <= 2'd0;
    end else begin
      rd_addr_q <= rd_addr_d;
      hold_q    <= hold_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      data_q[0] <= data_d[0];
      data_q[1] <= data_d[1];
      last_q    <= last_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
    end
  end

  assign rden         = issue_s;
  assign address2     = issue_s ? rd_addr_q : hold_q;
  assign m_if.m_valid = valid_s;
  assign m_if.m_data  = valid_s ? data_q[rd_ptr_q] : {DW{1'b0}};
  assign m_if.m_last  = valid_s && head_last_s;
  assign busy         = (state_q != IDLE);
  assign done         = done_q || finish_s;
  assign err          = err_q;

endmodule

// File: tb/tb_fire_bank_reader.sv
// Randomized self-checking bench for fire_bank_reader against a burst-level model.
module tb_fire_bank_reader;
  localparam int LANES  = 8;
  localparam int DEPTH  = 12321;
  localparam int ADDR_W = 32;
  localparam int DW     = 16*LANES;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W-1:0] pix_count = '0;
  logic              rden;
  logic [ADDR_W-1:0] address2;
  logic [DW-1:0]     bank_data;
  logic              busy, done, err;
  logic [15:0]       salt = 16'h0;
  bit                lane_mix = 1'b0;
  int                ready_mode = 0;
  int                cyc = 0;
  int                start_cyc = 0;
  int                checks = 0;
  int                errors = 0;

  fire_bank_reader_if #(.LANES(LANES)) m_if ();

  fire_bank_reader #(.LANES(LANES), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .pix_count(pix_count),
    .abort(abort), .rden(rden), .address2(address2), .bank_data(bank_data),
    .m_if(m_if), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bank contents: word n is n (xor salt) in every lane, optionally lane-distinguished.
  function automatic logic [DW-1:0] bank_word(input logic [ADDR_W-1:0] a, input logic [15:0] s, input bit mix);
    logic [15:0] n;
    logic [DW-1:0] w;
    n = a[15:0] ^ s;
    for (int k = 0; k < LANES; k++) w[16*k +: 16] = mix ? (n ^ 16'(k << 12)) : n;
    return w;
  endfunction

  assign bank_data = bank_word(address2, salt, lane_mix);

  // Observation log, sampled on the falling edge.
  logic [DW-1:0]     beat_q[$];
  bit                beat_last_q[$];
  int                beat_cyc_q[$];
  logic [ADDR_W-1:0] rd_addr_q[$];
  int                rd_cyc_q[$];
  int done_cnt, done_cyc, err_cnt, err_cyc, valid_cnt, busy_cnt, stall_bad, outstanding, max_out;
  bit prev_stall, prev_break, prev_last;
  logic [DW-1:0] prev_data;

  always @(negedge clk) begin
    if (rden) begin rd_addr_q.push_back(address2); rd_cyc_q.push_back(cyc); outstanding++; end
    if (m_if.m_valid) valid_cnt++;
    if (busy) busy_cnt++;
    if (m_if.m_valid && m_if.m_ready) begin
      beat_q.push_back(m_if.m_data); beat_last_q.push_back(m_if.m_last); beat_cyc_q.push_back(cyc);
      outstanding--;
    end
    if (outstanding > max_out) max_out = outstanding;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (err) begin err_cnt++; err_cyc = cyc; end
    if (prev_stall && !prev_break &&
        (!m_if.m_valid || m_if.m_data !== prev_data || m_if.m_last !== prev_last)) stall_bad++;
    prev_stall = m_if.m_valid && !m_if.m_ready;
    prev_data  = m_if.m_data;
    prev_last  = m_if.m_last;
    prev_break = abort || !rst;
  end

  task automatic clear_mon();
    beat_q.delete(); beat_last_q.delete(); beat_cyc_q.delete();
    rd_addr_q.delete(); rd_cyc_q.delete();
    done_cnt = 0; err_cnt = 0; valid_cnt = 0; busy_cnt = 0; stall_bad = 0;
    outstanding = 0; max_out = 0; prev_stall = 0; done_cyc = -1; err_cyc = -1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    case (ready_mode)
      0: m_if.m_ready = 1'b1;
      1: m_if.m_ready = ~m_if.m_ready;
      2: m_if.m_ready = 1'($urandom_range(0, 1));
      3: m_if.m_ready = 1'b0;
      default: m_if.m_ready = 1'b1;
    endcase
  endtask

  task automatic run_burst(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] n, input int budget, output bit to);
    base_addr = b; pix_count = n; start = 1'b1; start_cyc = cyc;
    tick();
    start = 1'b0;
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (!busy) begin to = 1'b0; break; end
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0; ready_mode = 0; m_if.m_ready = 1'b1;
    repeat (3) tick();
    checks++; if ({rden, busy, done, err, m_if.m_valid, m_if.m_last} !== 6'b0)
      begin errors++; $display("FAIL reset_flags got %b want 000000", {rden, busy, done, err, m_if.m_valid, m_if.m_last}); end
    checks++; if (address2 !== '0) begin errors++; $display("FAIL reset_addr got %0h want 0", address2); end
    checks++; if (m_if.m_data !== '0) begin errors++; $display("FAIL reset_data got %0h want 0", m_if.m_data); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    bit to;
    salt = 16'h0; lane_mix = 1'b0; ready_mode = 0; m_if.m_ready = 1'b1;
    clear_mon();
    run_burst(0, 4, 40, to);
    checks++; if (to) begin errors++; $display("FAIL basic_timeout got busy want idle"); end
    checks++; if (rd_addr_q.size() != 4) begin errors++; $display("FAIL basic_reads got %0d want 4", rd_addr_q.size()); end
    for (int i = 0; i < 4 && i < rd_addr_q.size(); i++) begin
      checks++; if (rd_addr_q[i] !== 32'(i) || rd_cyc_q[i] != start_cyc + 1 + i)
        begin errors++; $display("FAIL basic_rd%0d got addr %0d cyc %0d want addr %0d cyc %0d", i, rd_addr_q[i], rd_cyc_q[i], i, start_cyc + 1 + i); end
    end
    checks++; if (beat_q.size() != 4) begin errors++; $display("FAIL basic_beats got %0d want 4", beat_q.size()); end
    for (int i = 0; i < 4 && i < beat_q.size(); i++) begin
      logic [15:0] n16;
      n16 = 16'(i);
      checks++; if (beat_q[i] !== {LANES{n16}} || beat_last_q[i] !== (i == 3) || beat_cyc_q[i] != start_cyc + 2 + i)
        begin errors++; $display("FAIL basic_beat%0d got %0h last %0b cyc %0d want %0h last %0b cyc %0d", i, beat_q[i], beat_last_q[i], beat_cyc_q[i], {LANES{n16}}, (i == 3), start_cyc + 2 + i); end
    end
    checks++; if (done_cnt != 1 || done_cyc != start_cyc + 5)
      begin errors++; $display("FAIL basic_done got cnt %0d cyc %0d want cnt 1 cyc %0d", done_cnt, done_cyc, start_cyc + 5); end
  endtask

  task automatic test_stall();
    bit to;
    logic [ADDR_W-1:0] b;
    b = ADDR_W'($urandom_range(0, 1000));
    salt = 16'($urandom); lane_mix = 1'b1; ready_mode = 1; m_if.m_ready = 1'b1;
    clear_mon();
    run_burst(b, 5, 60, to);
    checks++; if (to) begin errors++; $display("FAIL stall_timeout got busy want idle"); end
    checks++; if (beat_q.size() != 5) begin errors++; $display("FAIL stall_beats got %0d want 5", beat_q.size()); end
    for (int i = 0; i < 5 && i < beat_q.size(); i++) begin
      checks++; if (beat_q[i] !== bank_word(b + ADDR_W'(i), salt, 1'b1) || beat_last_q[i] !== (i == 4))
        begin errors++; $display("FAIL stall_beat%0d got %0h last %0b want %0h last %0b", i, beat_q[i], beat_last_q[i], bank_word(b + ADDR_W'(i), salt, 1'b1), (i == 4)); end
    end
    checks++; if (stall_bad != 0) begin errors++; $display("FAIL stall_stable got %0d changes want 0", stall_bad); end
    checks++; if (max_out > 2) begin errors++; $display("FAIL stall_outstanding got %0d want <=2", max_out); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL stall_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_boundary();
    bit to;
    salt = 16'h0; lane_mix = 1'b1; ready_mode = 0; m_if.m_ready = 1'b1;
    clear_mon();
    run_burst(12320, 1, 20, to);
    checks++; if (to || beat_q.size() != 1) begin errors++; $display("FAIL edge1_beats got %0d want 1", beat_q.size()); end
    else begin
      checks++; if (beat_q[0] !== bank_word(12320, 16'h0, 1'b1) || beat_last_q[0] !== 1'b1)
        begin errors++; $display("FAIL edge1_beat got %0h last %0b want %0h last 1", beat_q[0], beat_last_q[0], bank_word(12320, 16'h0, 1'b1)); end
    end
    clear_mon();
    run_burst(12320, 2, 20, to);
    checks++; if (err_cnt != 1 || err_cyc != start_cyc + 1)
      begin errors++; $display("FAIL edge2_err got cnt %0d cyc %0d want cnt 1 cyc %0d", err_cnt, err_cyc, start_cyc + 1); end
    checks++; if (rd_addr_q.size() != 0 || busy_cnt != 0 || done_cnt != 0)
      begin errors++; $display("FAIL edge2_quiet got reads %0d busy %0d done %0d want 0 0 0", rd_addr_q.size(), busy_cnt, done_cnt); end
  endtask

  task automatic test_zero();
    bit to;
    ready_mode = 0; clear_mon();
    run_burst(ADDR_W'($urandom_range(0, 5000)), 0, 20, to);
    checks++; if (done_cnt != 1 || done_cyc != start_cyc + 1)
      begin errors++; $display("FAIL zero_done got cnt %0d cyc %0d want cnt 1 cyc %0d", done_cnt, done_cyc, start_cyc + 1); end
    checks++; if (valid_cnt != 0 || err_cnt != 0 || busy_cnt != 0)
      begin errors++; $display("FAIL zero_quiet got valid %0d err %0d busy %0d want 0 0 0", valid_cnt, err_cnt, busy_cnt); end
  endtask

  task automatic test_abort();
    bit to;
    logic [ADDR_W-1:0] b;
    b = ADDR_W'($urandom_range(0, 8000));
    salt = 16'($urandom); lane_mix = 1'b1; ready_mode = 0; m_if.m_ready = 1'b1;
    clear_mon();
    base_addr = b; pix_count = 6; start = 1'b1;
    tick();
    start = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (beat_q.size() >= 2) begin to = 1'b0; break; end
      tick();
    end
    checks++; if (to) begin errors++; $display("FAIL abort_wait got %0d beats want 2", beat_q.size()); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (m_if.m_valid !== 1'b0 || busy !== 1'b0 || rden !== 1'b0)
      begin errors++; $display("FAIL abort_flush got valid %b busy %b rden %b want 0 0 0", m_if.m_valid, busy, rden); end
    repeat (4) tick();
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL abort_nodone got %0d want 0", done_cnt); end
    // Abort wins over a simultaneous start.
    clear_mon();
    base_addr = b; pix_count = 3; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    repeat (3) tick();
    checks++; if (busy_cnt != 0 || done_cnt != 0 || err_cnt != 0)
      begin errors++; $display("FAIL abort_prio got busy %0d done %0d err %0d want 0 0 0", busy_cnt, done_cnt, err_cnt); end
    clear_mon();
    run_burst(b + 7, 3, 30, to);
    checks++; if (to || beat_q.size() != 3 || done_cnt != 1)
      begin errors++; $display("FAIL abort_after got beats %0d done %0d want 3 1", beat_q.size(), done_cnt); end
    for (int i = 0; i < 3 && i < beat_q.size(); i++) begin
      checks++; if (beat_q[i] !== bank_word(b + 7 + ADDR_W'(i), salt, 1'b1) || beat_last_q[i] !== (i == 2))
        begin errors++; $display("FAIL abort_after%0d got %0h want %0h", i, beat_q[i], bank_word(b + 7 + ADDR_W'(i), salt, 1'b1)); end
    end
  endtask

  task automatic test_busy_start();
    logic [ADDR_W-1:0] b;
    bit to;
    b = ADDR_W'($urandom_range(0, 8000));
    salt = 16'($urandom); lane_mix = 1'b1; ready_mode = 0; m_if.m_ready = 1'b1;
    clear_mon();
    base_addr = b; pix_count = 5; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    base_addr = b + 100; pix_count = 3; start = 1'b1;
    tick();
    start = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!busy) begin to = 1'b0; break; end
    end
    repeat (6) tick();
    checks++; if (to || beat_q.size() != 5 || done_cnt != 1 || busy !== 1'b0)
      begin errors++; $display("FAIL busy_start got beats %0d done %0d want 5 1", beat_q.size(), done_cnt); end
    for (int i = 0; i < 5 && i < beat_q.size(); i++) begin
      checks++; if (beat_q[i] !== bank_word(b + ADDR_W'(i), salt, 1'b1))
        begin errors++; $display("FAIL busy_beat%0d got %0h want %0h", i, beat_q[i], bank_word(b + ADDR_W'(i), salt, 1'b1)); end
    end
  endtask

  task automatic test_reset_mid();
    salt = 16'($urandom); lane_mix = 1'b1; ready_mode = 3; m_if.m_ready = 1'b0;
    clear_mon();
    base_addr = 50; pix_count = 6; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    checks++; if (m_if.m_valid !== 1'b1 || busy !== 1'b1)
      begin errors++; $display("FAIL rstmid_pre got valid %b busy %b want 1 1", m_if.m_valid, busy); end
    rst = 1'b0;
    tick();
    checks++; if ({rden, busy, done, err, m_if.m_valid, m_if.m_last} !== 6'b0 || address2 !== '0 || m_if.m_data !== '0)
      begin errors++; $display("FAIL rstmid_out got flags %b addr %0h data %0h want 0", {rden, busy, done, err, m_if.m_valid, m_if.m_last}, address2, m_if.m_data); end
    rst = 1'b1;
    clear_mon();
    ready_mode = 0;
    repeat (8) tick();
    checks++; if (beat_q.size() != 0 || done_cnt != 0 || rd_addr_q.size() != 0)
      begin errors++; $display("FAIL rstmid_after got beats %0d done %0d reads %0d want 0 0 0", beat_q.size(), done_cnt, rd_addr_q.size()); end
  endtask

  task automatic test_random();
    for (int t = 0; t < 24; t++) begin
      logic [ADDR_W-1:0] b, n;
      bit to;
      longint sum;
      if ($urandom_range(0, 4) == 0) begin
        b = ADDR_W'(DEPTH - $urandom_range(0, 3));
        n = ADDR_W'($urandom_range(5, 8));
      end else begin
        b = ADDR_W'($urandom_range(0, DEPTH - 12));
        n = ADDR_W'($urandom_range(0, 10));
      end
      sum = longint'(b) + longint'(n);
      salt = 16'($urandom); lane_mix = 1'b1; ready_mode = 2;
      clear_mon();
      run_burst(b, n, 30 * int'(n) + 20, to);
      checks++; if (to) begin errors++; $display("FAIL rand%0d_timeout got busy want idle", t); end
      if (n == 0) begin
        checks++; if (done_cnt != 1 || valid_cnt != 0 || err_cnt != 0)
          begin errors++; $display("FAIL rand%0d_zero got done %0d valid %0d err %0d want 1 0 0", t, done_cnt, valid_cnt, err_cnt); end
      end else if (sum > DEPTH) begin
        checks++; if (err_cnt != 1 || rd_addr_q.size() != 0 || done_cnt != 0)
          begin errors++; $display("FAIL rand%0d_range got err %0d reads %0d done %0d want 1 0 0", t, err_cnt, rd_addr_q.size(), done_cnt); end
      end else begin
        checks++; if (beat_q.size() != int'(n) || rd_addr_q.size() != int'(n) || done_cnt != 1 || err_cnt != 0)
          begin errors++; $display("FAIL rand%0d_count got beats %0d reads %0d done %0d want %0d %0d 1", t, beat_q.size(), rd_addr_q.size(), done_cnt, n, n); end
        for (int i = 0; i < int'(n) && i < beat_q.size() && i < rd_addr_q.size(); i++) begin
          checks++; if (rd_addr_q[i] !== b + ADDR_W'(i) || beat_q[i] !== bank_word(b + ADDR_W'(i), salt, 1'b1) || beat_last_q[i] !== (i == int'(n) - 1))
            begin errors++; $display("FAIL rand%0d_beat%0d got addr %0d data %0h last %0b want addr %0d data %0h", t, i, rd_addr_q[i], beat_q[i], beat_last_q[i], b + ADDR_W'(i), bank_word(b + ADDR_W'(i), salt, 1'b1)); end
        end
        if (beat_cyc_q.size() != 0) begin
          checks++; if (done_cyc != beat_cyc_q[beat_cyc_q.size() - 1])
            begin errors++; $display("FAIL rand%0d_donecyc got %0d want %0d", t, done_cyc, beat_cyc_q[beat_cyc_q.size() - 1]); end
        end
        checks++; if (stall_bad != 0 || max_out > 2)
          begin errors++; $display("FAIL rand%0d_flow got unstable %0d outstanding %0d want 0 <=2", t, stall_bad, max_out); end
      end
    end
  endtask

  initial begin
    m_if.m_ready = 1'b1;
    clear_mon();
    test_reset();
    test_basic();
    test_stall();
    test_boundary();
    test_zero();
    test_abort();
    test_busy_start();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no completion want finish");
    $fatal(1);
  end
endmodule

// File: doc/fire_bank_reader.md
FIRE_BANK_READER -- requirements
Module: fire_bank_reader

Interface
REQ-001 SHALL have parameter LANES, default 8, number of parallel 16-bit banks read per access.
REQ-002 SHALL have parameter DEPTH, default 12321 (111*111), words per bank.
REQ-003 SHALL have parameter ADDR_W, default 32, bank address width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-005 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a read burst.
REQ-007 SHALL have port base_addr  input  ADDR_W  first bank word address of the burst.
REQ-008 SHALL have port pix_count  input  ADDR_W  number of words in the burst.
REQ-009 SHALL have port abort  input  1  flush the current burst.
REQ-010 SHALL have port rden  output  1  bank read enable.
REQ-011 SHALL have port address2  output  ADDR_W  bank read address.
REQ-012 SHALL have port bank_data  input  16*LANES  combinational bank read data; lane k at bits [16k+15:16k], lane 0 = bank1.
REQ-013 SHALL have port m_data  output  16*LANES  streamed word, same lane order as bank_data.
REQ-014 SHALL have port m_valid  output  1  m_data holds a valid beat.
REQ-015 SHALL have port m_ready  input  1  downstream accepts a beat.
REQ-016 SHALL have port m_last  output  1  marks the final beat of a burst.
REQ-017 SHALL have port busy  output  1  high in any state except IDLE.
REQ-018 SHALL have port done  output  1  one-cycle pulse at burst completion.
REQ-019 SHALL have port err  output  1  one-cycle pulse on a rejected start.

Function
REQ-020 SHALL implement FSM states IDLE, READ, DRAIN.
REQ-021 SHALL, in IDLE with start=1, pix_count>0 and base_addr+pix_count<=DEPTH, latch base_addr and pix_count and enter READ next cycle.
REQ-022 SHALL, in IDLE with start=1 and pix_count=0, stay in IDLE and pulse done the next cycle with no beats emitted.
REQ-023 SHALL, in IDLE with start=1 and base_addr+pix_count>DEPTH, stay in IDLE and pulse err the next cycle (sum computed at ADDR_W+1 bits).
REQ-024 SHALL ignore start while busy=1.
REQ-025 SHALL buffer beats in an internal 2-entry FIFO.
REQ-026 SHALL, in READ, issue a read (rden=1, address2=latched base + issue index) in a cycle only if FIFO occupancy after that cycle's pop is below 2.
REQ-027 SHALL push bank_data into the FIFO in the same cycle as the issuing read (bank read is combinational), tagged last when issue index = pix_count-1.
REQ-028 SHALL drive rden=0 when not issuing and hold address2 at its last issued value.
REQ-029 SHALL present the FIFO head on m_data/m_last with m_valid=1 whenever the FIFO is non-empty; a beat transfers when m_valid and m_ready are both 1.
REQ-030 SHALL keep m_data, m_last and m_valid stable while m_valid=1 and m_ready=0.
REQ-031 SHALL support simultaneous push and pop when occupancy is 1 or 2, sustaining 1 beat/cycle when m_ready is held high.
REQ-032 SHALL move from READ to DRAIN in the cycle after the last read issues.
REQ-033 SHALL, in DRAIN, pulse done in the cycle the last beat transfers and enter IDLE next cycle.
REQ-034 SHALL, on abort=1 in any state, empty the FIFO, deassert m_valid and rden next cycle, enter IDLE, and generate no done pulse.
REQ-035 SHALL give abort priority over start in the same cycle.

Reset
REQ-036 SHALL, when rst=0 at a posedge clk, enter IDLE, empty the FIFO, and set rden=0, address2=0, m_valid=0, m_last=0, m_data=0, busy=0, done=0, err=0.
REQ-037 SHALL treat reset mid-burst identically to REQ-036, with no done pulse and no further beats.

Verification
REQ-038 SHALL verify: base_addr=0, pix_count=4, m_ready=1, bank word n = {8{n}} -> rden high 4 cycles at addresses 0..3, 4 beats on consecutive cycles, m_last on beat 3, done with beat 3.
REQ-039 SHALL verify: pix_count=5, m_ready toggling 1/0 -> 5 beats in order, data held stable during stalls, never more than 2 issued-but-unaccepted reads.
REQ-040 SHALL verify: base_addr=12320, pix_count=1 -> single beat with m_last=1; base_addr=12320, pix_count=2 -> err pulse, no rden, busy=0.
REQ-041 SHALL verify: pix_count=0 -> done one cycle after start, m_valid never 1.
REQ-042 SHALL verify: abort asserted after 2 of 6 beats -> m_valid=0 next cycle, IDLE, no done; a following start with pix_count=3 runs normally.
REQ-043 SHALL verify: rst=0 mid-burst with m_valid=1 -> all outputs at REQ-036 values on the next cycle; start during busy ignored.
